// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - request/pattern inputs and digit outputs of the display arbiter
interface display_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] pat;
  logic [6:0]         segmentos;
  logic [N_REQ-1:0]   grant;
  logic               advance;
  logic               busy;

  modport master (
    output req, pat,
    input  segmentos, grant, advance, busy
  );

  modport slave (
    input  req, pat,
    output segmentos, grant, advance, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin owner of the single seven-segment digit
// Grants one source for a fixed window, pulses its animation step, then blanks the digit.
module display_arbiter #(
  parameter int N_REQ = 3,
  parameter int HOLD  = 1000,
  parameter int STEP  = 250,
  parameter int GAP   = 4
) (
  input  logic          clock,
  input  logic          reset,
  display_arbiter_if.slave bus
);
  localparam int LW  = $clog2(N_REQ);
  localparam int MX1 = (HOLD > STEP) ? HOLD : STEP;
  localparam int MX  = (MX1 > GAP) ? MX1 : GAP;
  localparam int CW  = $clog2(MX + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  state_t          state;
  logic [LW-1:0]   last;
  logic [CW-1:0]   hold_cnt;
  logic [CW-1:0]   step_cnt;
  logic [CW-1:0]   gap_cnt;
  logic [CW-1:0]   step_nxt;
  logic            found;
  logic [LW-1:0]   winner;
  logic [LW-1:0]   idx;

  // First asserted request after the previous owner; wraps so a lone requester can win again.
  always_comb begin
    found  = 1'b0;
    winner = last;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = LW'((int'(last) + i) % N_REQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    step_nxt = (step_cnt == CW'(STEP - 1)) ? '0 : step_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last          <= LW'(N_REQ - 1);
      hold_cnt      <= '0;
      step_cnt      <= '0;
      gap_cnt       <= '0;
      bus.segmentos <= '0;
      bus.grant     <= '0;
      bus.advance   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state         <= ST_SHOW;
            last          <= winner;
            bus.grant     <= ONE << winner;
            bus.segmentos <= bus.pat[7*winner +: 7];
            bus.advance   <= (STEP == 1);
            bus.busy      <= 1'b1;
            hold_cnt      <= '0;
            step_cnt      <= '0;
          end
        end
        ST_SHOW: begin
          if (hold_cnt == CW'(HOLD - 1) || !bus.req[last]) begin
            state         <= ST_GAP;
            bus.grant     <= '0;
            bus.segmentos <= '0;
            bus.advance   <= 1'b0;
            gap_cnt       <= '0;
          end else begin
            hold_cnt      <= hold_cnt + 1'b1;
            step_cnt      <= step_nxt;
            // step_cnt tracks k mod STEP, so the pulse lands where (k+1) mod STEP == 0
            bus.advance   <= (step_nxt == CW'(STEP - 1));
            bus.segmentos <= bus.pat[7*last +: 7];
          end
        end
        ST_GAP: begin
          if (gap_cnt == CW'(GAP - 1)) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt  <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - randomized and directed check of display_arbiter against an ownership model
module tb_display_arbiter;
  localparam int N_REQ = 3;
  localparam int HOLD  = 8;
  localparam int STEP  = 4;
  localparam int GAP   = 2;
  localparam int PW    = 7 * N_REQ;

  logic clock = 1'b0;
  logic reset = 1'b0;

  display_arbiter_if #(.N_REQ(N_REQ)) bus ();

  display_arbiter #(
    .N_REQ(N_REQ), .HOLD(HOLD), .STEP(STEP), .GAP(GAP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference: who owns the digit, how far into the window, how many blank cycles remain.
  int         m_owner;
  int         m_k;
  int         m_blank;
  int         m_last;
  logic [6:0] m_seg;

  int               adv_cnt;
  int               grant_rise;
  logic [N_REQ-1:0] prev_grant;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_k     = 0;
    m_blank = 0;
    m_last  = N_REQ - 1;
    m_seg   = '0;
  endtask

  task automatic model_step();
    if (m_owner >= 0) begin
      if (m_k == HOLD - 1 || !bus.req[m_owner]) begin
        m_owner = -1;
        m_blank = GAP;
        m_seg   = '0;
      end else begin
        m_k++;
        m_seg = bus.pat[7*m_owner +: 7];
      end
    end else if (m_blank > 0) begin
      m_blank--;
    end else if (bus.req != '0) begin
      for (int i = 1; i <= N_REQ; i++) begin
        if (m_owner < 0 && bus.req[(m_last + i) % N_REQ]) m_owner = (m_last + i) % N_REQ;
      end
      m_last = m_owner;
      m_k    = 0;
      m_seg  = bus.pat[7*m_owner +: 7];
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    check_eq("grant", 32'(bus.grant), exp_grant);
    check_eq("segmentos", 32'(bus.segmentos), 32'(m_seg));
    check_eq("advance", 32'(bus.advance), 32'(m_owner >= 0 && ((m_k + 1) % STEP) == 0));
    check_eq("busy", 32'(bus.busy), 32'(m_owner >= 0 || m_blank > 0));
    if (bus.advance) adv_cnt++;
    if (bus.grant != '0 && prev_grant == '0) grant_rise++;
    prev_grant = bus.grant;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    else       model_reset();
    #1;
    check_all();
  endtask

  // Leaves reset asserted; caller sets inputs and releases it.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int c = 0; c < cycles; c++) begin
      bus.req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      bus.pat = PW'($urandom);
      tick();
    end
  endtask

  task automatic clear_counts();
    adv_cnt    = 0;
    grant_rise = 0;
    prev_grant = '0;
  endtask

  initial begin
    bus.req = '0;
    bus.pat = '0;
    model_reset();
    clear_counts();

    // Reset with random inputs, then a lone requester over two full ownerships
    do_reset(3);
    bus.req = 3'b001;
    bus.pat = {7'h00, 7'h00, 7'h3F};
    reset   = 1'b1;
    clear_counts();
    repeat (2 * (HOLD + GAP + 1)) tick();
    check_eq("single_adv_count", 32'(adv_cnt), 32'd4);
    check_eq("single_grant_count", 32'(grant_rise), 32'd2);

    // Round-robin with all three requesting
    do_reset(2);
    bus.req = 3'b111;
    bus.pat = {7'h04, 7'h02, 7'h01};
    reset   = 1'b1;
    clear_counts();
    repeat (4 * (HOLD + GAP + 1)) tick();
    check_eq("rr_adv_count", 32'(adv_cnt), 32'd8);
    check_eq("rr_grant_count", 32'(grant_rise), 32'd4);

    // Early release at k=2
    do_reset(2);
    bus.req = 3'b010;
    bus.pat = {7'h11, 7'h5A, 7'h22};
    reset   = 1'b1;
    repeat (3) tick();
    bus.req = 3'b000;
    clear_counts();
    repeat (6) tick();
    check_eq("early_no_adv", 32'(adv_cnt), 32'd0);

    // Reset mid-SHOW at k=5 while source 1 owns, then 101 must go to 0 first
    do_reset(2);
    bus.req = 3'b010;
    bus.pat = {7'h44, 7'h33, 7'h22};
    reset   = 1'b1;
    repeat (6) tick();
    do_reset(0);
    check_eq("midshow_reset_grant", 32'(bus.grant), 32'd0);
    bus.req = 3'b101;
    reset   = 1'b1;
    tick();
    check_eq("after_reset_first", 32'(bus.grant), 32'b001);
    repeat (HOLD + GAP + 1) tick();
    check_eq("after_reset_second", 32'(bus.grant), 32'b100);
    repeat (4) tick();

    // Live pattern change at k=4
    do_reset(2);
    bus.req = 3'b001;
    bus.pat = {7'h00, 7'h00, 7'h3F};
    reset   = 1'b1;
    repeat (5) tick();
    bus.pat[6:0] = 7'h06;
    tick();
    check_eq("live_pat", 32'(bus.segmentos), 32'h06);
    repeat (8) tick();

    // Random traffic with occasional asynchronous resets
    do_reset(1);
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset(2);
        reset = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) bus.req = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
      if ($urandom_range(0, 7) == 0) bus.pat = PW'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single seven-segment digit of the irrigation panel between several message sources (sensor alarm, push-button status, timer message). Grants the digit to one requester at a time in round-robin order, holds it for a fixed window, and blanks the digit for a short gap between owners. While a source is granted, the block issues periodic `advance` pulses that step that source's six-state animation counter.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters, ≥ 2.
- `HOLD`, 1000: SHOW window length in cycles, ≥ 1.
- `STEP`, 250: cycles between `advance` pulses, ≥ 1.
- `GAP`, 4: blank cycles between owners, ≥ 1.

Ports:
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level request per source; bit i belongs to source i.
- `pat`  in  7*N_REQ  segment pattern per source; source i occupies bits [7i+6:7i]; bit 0 = a, bit 6 = g.
- `segmentos`  out  7  registered segment drive; a = bit 0, g = bit 6.
- `grant`  out  N_REQ  registered, one-hot or zero; marks the current owner.
- `advance`  out  1  one-cycle pulse to the owner's animation counter.
- `busy`  out  1  high in SHOW and GAP.

## Operation
- States: IDLE, SHOW, GAP. The round-robin pointer `last` is internal, `$clog2(N_REQ)` bits wide.
- **Reset (asynchronous, `reset` = 0):**
  - State goes to IDLE.
  - `segmentos`, `grant`, `advance` and `busy` go to 0.
  - `last` = N_REQ-1, so source 0 wins first.
  - Hold, step and gap counters go to 0.
  - Reset asserted mid-SHOW or mid-GAP aborts the operation immediately, with no completion cycle.
- **IDLE:**
  - If `req` = 0, stay in IDLE with outputs at 0.
  - Otherwise pick the first asserted bit scanning last+1, last+2, … modulo N_REQ.
  - Next cycle: state = SHOW, `grant` = one-hot(winner), `last` = winner, hold and step counters = 0.
- **SHOW (owner g, show index k starting at 0):**
  - `segmentos` <= pat[g] every cycle, so the output tracks live pattern changes with a 1-cycle lag.
  - `advance` is high during SHOW cycle k iff (k+1) mod STEP == 0.
  - Exit to GAP after cycle k = HOLD-1.
  - Early exit: if req[g] is sampled 0 in any SHOW cycle, the next cycle is GAP. No `advance` is issued on the exit cycle unless the pulse condition already held in that cycle.
- **GAP:**
  - `segmentos` = 0, `grant` = 0, `advance` = 0, `busy` = 1.
  - After GAP cycles, state = IDLE, and arbitration happens in that IDLE cycle.
- Requests arriving during SHOW or GAP are not lost; they are served by the next IDLE arbitration. A requester whose bit drops before arbitration is skipped.
- Counters are sized `$clog2(max(HOLD,STEP,GAP)+1)` bits and never overflow; each clears on state entry.
- `busy` = (state != IDLE), registered.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled in IDLE at edge t gives `grant`/`segmentos` valid after edge t+1.
- One full ownership lasts HOLD SHOW cycles + GAP blank cycles + 1 IDLE arbitration cycle. With continuous requests, the owner period is HOLD+GAP+1 cycles.
- `advance` count per full SHOW = floor(HOLD/STEP).
- A requester that stays asserted with no other requests is re-granted after GAP+1 cycles; the pointer permits self re-grant when no other bit is set.
- No combinational path from any input to any output.

## Test plan
Use N_REQ=3, HOLD=8, STEP=4, GAP=2.
1. **Reset:** hold `reset`=0 with random `req`/`pat`. Required: `segmentos`=0, `grant`=000, `advance`=0, `busy`=0.
2. **Single requester:** `req`=001, pat[0]=7'h3F, held. Required:
   - `grant`=001 and `segmentos`=3F from the cycle after the request.
   - `advance` high at k=3 and k=7.
   - 2 blank cycles, then 1 IDLE cycle, then `grant`=001 again.
3. **Round-robin:** `req`=111, distinct patterns 01/02/04. Required: grant sequence 001, 010, 100, 001, each with its own pattern and exactly 2 `advance` pulses per window.
4. **Early release:** `req`=010; drop req[1] at k=2. Required: GAP entered the next cycle, `segmentos`=0, no further `advance`, IDLE after 2 cycles.
5. **Reset mid-SHOW:** assert `reset`=0 at k=5 while source 1 owns the digit. Required: outputs 0 immediately. After release with `req`=101, `grant`=001 first, then 100.
6. **Live pattern:** change pat[0] from 3F to 06 at k=4. Required: `segmentos`=06 from k=5 onward.
